sa_onehot_clk_ctrl: RTL and testbench

Parametrised one-hot clock-enable controller for DFT of multi-port asynchronous buffers. It generalises the fixed two-port read/write one-hot scheme to NUM_PORTS clock-gate enables. Under test control it walks the ports one at a time, with a programmable dwell and a break-before-make gap, so that exactly one port clock is live per pattern window. In functional mode it passes the functional enables through a register stage. It sits next to the clock gates of async FIFOs and multi-port RAM wrappers.

---
 rtl/sa_onehot_clk_ctrl.sv | 127 ++++++++++++
 tb/tb_sa_onehot_clk_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_onehot_clk_ctrl.sv
// One-hot clock-enable controller: walks NUM_PORTS clock-gate enables one at a time
// in test mode with a break-before-make gap, or registers functional enables otherwise.
module sa_onehot_clk_ctrl #(
    parameter  int NUM_PORTS  = 2,
    parameter  int CNT_W      = 8,
    parameter  int GAP_CYCLES = 2,
    localparam int IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                 sa_core_clk,
    input  logic                 sa_core_rstn,
    input  logic                 one_hot_enable,
    input  logic                 auto_mode,
    input  logic [CNT_W-1:0]     dwell,
    input  logic                 tp_step,
    input  logic [NUM_PORTS-1:0] func_en,
    output logic [NUM_PORTS-1:0] enable,
    output logic [IDX_W-1:0]     active_idx,
    output logic                 in_gap,
    output logic                 sweep_done
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_FUNC   = 2'd0,
        ST_GAP    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NUM_PORTS-1:0]   r_enable;
    logic [IDX_W-1:0]       r_active_idx;
    logic                   r_in_gap;
    logic                   r_sweep_done;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [CNT_W-1:0]       r_dwell_cnt;

    logic                   w_advance;
    logic                   w_last_port;
    logic [NUM_PORTS-1:0]   w_port_en;

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_PORTS-1:0] f;
        f      = '0;
        f[idx] = 1'b1;
        return f;
    endfunction

    assign w_port_en   = onehot(r_active_idx) & func_en;
    assign w_last_port = (r_active_idx == IDX_W'(NUM_PORTS - 1));
    // tp_step only counts in manual mode; auto mode compares against the live dwell value.
    assign w_advance   = auto_mode ? (r_dwell_cnt == dwell) : tp_step;

    always_ff @(posedge sa_core_clk or negedge sa_core_rstn) begin
        if (!sa_core_rstn) begin
            r_state      <= ST_FUNC;
            r_enable     <= '0;
            r_active_idx <= '0;
            r_in_gap     <= 1'b0;
            r_sweep_done <= 1'b0;
            r_gap_cnt    <= '0;
            r_dwell_cnt  <= '0;
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                ST_FUNC: begin
                    if (one_hot_enable) begin
                        r_state      <= ST_GAP;
                        r_in_gap     <= 1'b1;
                        r_enable     <= '0;
                        r_gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                        r_active_idx <= '0;
                    end else begin
                        r_enable     <= func_en;
                    end
                end
                ST_GAP: begin
                    r_enable <= '0;
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end else if (one_hot_enable) begin
                        r_state     <= ST_ACTIVE;
                        r_in_gap    <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_enable    <= w_port_en;
                    end else begin
                        r_state      <= ST_FUNC;
                        r_in_gap     <= 1'b0;
                        r_enable     <= func_en;
                        r_active_idx <= '0;
                    end
                end
                ST_ACTIVE: begin
                    r_enable <= w_port_en;
                    if (r_dwell_cnt != {CNT_W{1'b1}}) begin
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                    end
                    // Leaving test mode wins over an advance and never reports a sweep.
                    if (!one_hot_enable) begin
                        r_state   <= ST_GAP;
                        r_in_gap  <= 1'b1;
                        r_enable  <= '0;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end else if (w_advance) begin
                        r_state      <= ST_GAP;
                        r_in_gap     <= 1'b1;
                        r_enable     <= '0;
                        r_gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                        r_active_idx <= w_last_port ? '0 : r_active_idx + 1'b1;
                        r_sweep_done <= w_last_port;
                    end
                end
                default: begin
                    r_state  <= ST_FUNC;
                    r_in_gap <= 1'b0;
                    r_enable <= '0;
                end
            endcase
        end
    end

    assign enable     = r_enable;
    assign active_idx = r_active_idx;
    assign in_gap     = r_in_gap;
    assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_sa_onehot_clk_ctrl.sv
// Directed bench for sa_onehot_clk_ctrl with 4 ports, 2-cycle gap.
module tb_sa_onehot_clk_ctrl;

    localparam int NP    = 4;
    localparam int CW    = 8;
    localparam int GAP   = 2;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          one_hot;
    logic          auto_m;
    logic [CW-1:0] dwell;
    logic          tp;
    logic [NP-1:0] func_en;
    logic [NP-1:0] enable;
    logic [IW-1:0] active_idx;
    logic          in_gap;
    logic          sweep_done;

    int n_total = 0;
    int n_pass  = 0;

    sa_onehot_clk_ctrl #(
        .NUM_PORTS (NP),
        .CNT_W     (CW),
        .GAP_CYCLES(GAP)
    ) dut (
        .sa_core_clk   (clk),
        .sa_core_rstn  (rstn),
        .one_hot_enable(one_hot),
        .auto_mode     (auto_m),
        .dwell         (dwell),
        .tp_step       (tp),
        .func_en       (func_en),
        .enable        (enable),
        .active_idx    (active_idx),
        .in_gap        (in_gap),
        .sweep_done    (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        one_hot = 1'b0; auto_m = 1'b0; dwell = '0; tp = 1'b0; func_en = '0;
        rstn = 1'b0;
        #3;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        one_hot = 1'b0; auto_m = 1'b0; dwell = '0; tp = 1'b0; func_en = 4'b0011;
        rstn = 1'b0;
        #2;
        tick();
        n_total++;
        if ({enable, active_idx, in_gap, sweep_done} !== 8'h00)
            $display("FAIL reset_outputs got en=%b idx=%0d gap=%b sd=%b exp all zero",
                     enable, active_idx, in_gap, sweep_done);
        else n_pass++;
        rstn = 1'b1;
        n_total++;
        if (enable !== 4'b0000) $display("FAIL func_latency_pre got=%b exp=0000", enable);
        else n_pass++;
        tp = 1'b1;
        tick();
        tp = 1'b0;
        n_total++;
        if ({enable, active_idx, in_gap, sweep_done} !== {4'b0011, 2'd0, 1'b0, 1'b0})
            $display("FAIL func_passthru got en=%b idx=%0d gap=%b exp en=0011 idx=0 gap=0",
                     enable, active_idx, in_gap);
        else n_pass++;
        func_en = 4'b1100;
        tick();
        n_total++;
        if (enable !== 4'b1100) $display("FAIL func_passthru2 got=%b exp=1100", enable);
        else n_pass++;
    endtask

    task automatic test_auto_sweep();
        logic [NP-1:0] e_en;
        int k, port, pos;
        do_reset();
        auto_m = 1'b1; dwell = 8'd3; func_en = 4'hF; one_hot = 1'b1;
        for (int t = 1; t <= 48; t++) begin
            tick();
            k    = (t - 1) % 24;
            port = k / 6;
            pos  = k % 6;
            e_en = (pos < 2) ? 4'b0000 : (4'b0001 << port);
            n_total++;
            if ({enable, active_idx, in_gap, sweep_done} !==
                {e_en, IW'(port), (pos < 2), (t > 1 && k == 0)})
                $display("FAIL auto_sweep t=%0d got en=%b idx=%0d gap=%b sd=%b exp en=%b idx=%0d gap=%b sd=%b",
                         t, enable, active_idx, in_gap, sweep_done,
                         e_en, port, (pos < 2), (t > 1 && k == 0));
            else n_pass++;
        end
    endtask

    task automatic test_manual();
        // {tp, expected enable, expected idx, expected sweep_done} per cycle
        logic [7:0] tbl [19];
        tbl = '{ {1'b0,4'b0000,2'd0,1'b0}, {1'b0,4'b0000,2'd0,1'b0}, {1'b0,4'b0001,2'd0,1'b0},
                 {1'b0,4'b0001,2'd0,1'b0}, {1'b1,4'b0000,2'd1,1'b0}, {1'b1,4'b0000,2'd1,1'b0},
                 {1'b0,4'b0010,2'd1,1'b0}, {1'b0,4'b0010,2'd1,1'b0}, {1'b0,4'b0010,2'd1,1'b0},
                 {1'b1,4'b0000,2'd2,1'b0}, {1'b0,4'b0000,2'd2,1'b0}, {1'b0,4'b0100,2'd2,1'b0},
                 {1'b1,4'b0000,2'd3,1'b0}, {1'b0,4'b0000,2'd3,1'b0}, {1'b1,4'b1000,2'd3,1'b0},
                 {1'b0,4'b1000,2'd3,1'b0}, {1'b1,4'b0000,2'd0,1'b1}, {1'b0,4'b0000,2'd0,1'b0},
                 {1'b0,4'b0001,2'd0,1'b0} };
        do_reset();
        auto_m = 1'b0; dwell = 8'd0; func_en = 4'hF; one_hot = 1'b1;
        for (int t = 0; t < 19; t++) begin
            tp = tbl[t][7];
            tick();
            tp = 1'b0;
            n_total++;
            if ({enable, active_idx, sweep_done} !== tbl[t][6:0])
                $display("FAIL manual t=%0d got en=%b idx=%0d sd=%b exp en=%b idx=%0d sd=%b",
                         t, enable, active_idx, sweep_done, tbl[t][6:3], tbl[t][2:1], tbl[t][0]);
            else n_pass++;
        end
    endtask

    task automatic test_masked_port();
        logic [NP-1:0] e_en;
        int k, port, pos;
        do_reset();
        auto_m = 1'b1; dwell = 8'd2; func_en = 4'b1011; one_hot = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            k    = (t - 1) % 20;
            port = k / 5;
            pos  = k % 5;
            e_en = (pos < 2) ? 4'b0000 : ((4'b0001 << port) & 4'b1011);
            n_total++;
            if ({enable, active_idx, in_gap} !== {e_en, IW'(port), (pos < 2)})
                $display("FAIL masked_port t=%0d got en=%b idx=%0d gap=%b exp en=%b idx=%0d gap=%b",
                         t, enable, active_idx, in_gap, e_en, port, (pos < 2));
            else n_pass++;
        end
    endtask

    task automatic test_drop_mid_window();
        do_reset();
        auto_m = 1'b1; dwell = 8'd5; func_en = 4'hF; one_hot = 1'b1;
        repeat (11) tick();
        n_total++;
        if ({enable, active_idx} !== {4'b0010, 2'd1})
            $display("FAIL drop_pre got en=%b idx=%0d exp en=0010 idx=1", enable, active_idx);
        else n_pass++;
        one_hot = 1'b0;
        tick();
        n_total++;
        if ({enable, active_idx, in_gap, sweep_done} !== {4'b0000, 2'd1, 1'b1, 1'b0})
            $display("FAIL drop_gap1 got en=%b idx=%0d gap=%b sd=%b exp en=0000 idx=1 gap=1 sd=0",
                     enable, active_idx, in_gap, sweep_done);
        else n_pass++;
        func_en = 4'b0110;
        tick();
        n_total++;
        if ({enable, in_gap, sweep_done} !== {4'b0000, 1'b1, 1'b0})
            $display("FAIL drop_gap2 got en=%b gap=%b sd=%b exp en=0000 gap=1 sd=0",
                     enable, in_gap, sweep_done);
        else n_pass++;
        tick();
        n_total++;
        if ({enable, active_idx, in_gap, sweep_done} !== {4'b0110, 2'd0, 1'b0, 1'b0})
            $display("FAIL drop_func got en=%b idx=%0d gap=%b sd=%b exp en=0110 idx=0 gap=0 sd=0",
                     enable, active_idx, in_gap, sweep_done);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        auto_m = 1'b0; func_en = 4'hF; one_hot = 1'b1;
        repeat (3) tick();
        tp = 1'b1;
        tick();
        tp = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({enable, active_idx} !== {4'b0010, 2'd1})
            $display("FAIL arst_pre got en=%b idx=%0d exp en=0010 idx=1", enable, active_idx);
        else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        n_total++;
        if ({enable, active_idx, in_gap, sweep_done} !== 8'h00)
            $display("FAIL arst_immediate got en=%b idx=%0d gap=%b sd=%b exp all zero",
                     enable, active_idx, in_gap, sweep_done);
        else n_pass++;
        #1;
        rstn = 1'b1;
        one_hot = 1'b0; func_en = 4'b0101;
        tick();
        n_total++;
        if ({enable, active_idx, in_gap} !== {4'b0101, 2'd0, 1'b0})
            $display("FAIL arst_resume got en=%b idx=%0d gap=%b exp en=0101 idx=0 gap=0",
                     enable, active_idx, in_gap);
        else n_pass++;
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_auto_sweep();
        test_manual();
        test_masked_port();
        test_drop_mid_window();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
